// File: rtl/wire_cut_sequencer.sv
// Wire-cut stage controller: walks STAGE0..4 on correct cuts, counts strikes,
// runs a seconds countdown and latches WIN or LOSE until reset or disconnect.
module wire_cut_sequencer #(
  parameter int unsigned CYCLES_PER_SEC = 100_000_000,
  parameter int unsigned TIME_LIMIT_S   = 60,
  parameter int unsigned MAX_STRIKES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       is_connected,
  input  logic       cut_req,
  input  logic [2:0] cut_sel,
  output logic [2:0] cut_wire,
  output logic [1:0] strikes,
  output logic [7:0] time_left,
  output logic       cut_ok,
  output logic       cut_bad
);

  localparam int unsigned PRE_W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_STAGE0, S_STAGE1, S_STAGE2, S_STAGE3, S_STAGE4, S_WIN, S_LOSE
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         cut_wire_q, cut_wire_d;
  logic [1:0]         strikes_q, strikes_d;
  logic [7:0]         time_q, time_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               ok_q, ok_d;
  logic               bad_q, bad_d;
  logic               cut_req_q;

  logic               cut_evt;
  logic               sel_valid;
  logic               in_stage;
  logic [2:0]         stage_num;
  state_e             adv_state;
  logic               pre_wrap;

  // State and counter registers; the edge register samples every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cut_wire_q <= 3'd0;
      strikes_q  <= 2'd0;
      time_q     <= 8'(TIME_LIMIT_S);
      pre_q      <= '0;
      ok_q       <= 1'b0;
      bad_q      <= 1'b0;
      cut_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cut_wire_q <= cut_wire_d;
      strikes_q  <= strikes_d;
      time_q     <= time_d;
      pre_q      <= pre_d;
      ok_q       <= ok_d;
      bad_q      <= bad_d;
      cut_req_q  <= cut_req;
    end
  end

  // Stage decode: which wire is expected and where a correct cut leads.
  always_comb begin
    in_stage  = 1'b1;
    stage_num = 3'd0;
    adv_state = S_WIN;
    case (state_q)
      S_STAGE0: begin stage_num = 3'd0; adv_state = S_STAGE1; end
      S_STAGE1: begin stage_num = 3'd1; adv_state = S_STAGE2; end
      S_STAGE2: begin stage_num = 3'd2; adv_state = S_STAGE3; end
      S_STAGE3: begin stage_num = 3'd3; adv_state = S_STAGE4; end
      S_STAGE4: begin stage_num = 3'd4; adv_state = S_WIN;    end
      default:  in_stage = 1'b0;
    endcase
  end

  assign cut_evt   = cut_req & ~cut_req_q;
  assign sel_valid = (cut_sel >= 3'd1) && (cut_sel <= 3'd5);
  assign pre_wrap  = (pre_q == PRE_W'(CYCLES_PER_SEC - 1));

  // Next-state: disconnect beats timeout, timeout beats a cut.
  always_comb begin
    state_d   = state_q;
    strikes_d = strikes_q;
    time_d    = time_q;
    pre_d     = pre_q;
    ok_d      = 1'b0;
    bad_d     = 1'b0;

    if (!is_connected || (state_q == S_IDLE)) begin
      strikes_d = 2'd0;
      time_d    = 8'(TIME_LIMIT_S);
      pre_d     = '0;
      state_d   = is_connected ? S_STAGE0 : S_IDLE;
    end else if (in_stage) begin
      pre_d = pre_wrap ? '0 : pre_q + PRE_W'(1);
      if (pre_wrap) begin
        time_d = time_q - 8'd1;
      end
      if (pre_wrap && (time_q == 8'd1)) begin
        state_d = S_LOSE;
      end else if (cut_evt && sel_valid) begin
        if (cut_sel == 3'(stage_num + 3'd1)) begin
          ok_d    = 1'b1;
          state_d = adv_state;
        end else begin
          bad_d     = 1'b1;
          strikes_d = strikes_q + 2'd1;
          if ((strikes_q + 2'd1) == 2'(MAX_STRIKES)) begin
            state_d = S_LOSE;
          end
        end
      end
    end
  end

  // Display code follows the next state so it lands with the state change.
  always_comb begin
    cut_wire_d = 3'd0;
    case (state_d)
      S_STAGE0: cut_wire_d = 3'd0;
      S_STAGE1: cut_wire_d = 3'd1;
      S_STAGE2: cut_wire_d = 3'd2;
      S_STAGE3: cut_wire_d = 3'd3;
      S_STAGE4: cut_wire_d = 3'd4;
      S_WIN:    cut_wire_d = 3'd5;
      S_LOSE:   cut_wire_d = 3'd7;
      default:  cut_wire_d = 3'd0;
    endcase
  end

  assign cut_wire  = cut_wire_q;
  assign strikes   = strikes_q;
  assign time_left = time_q;
  assign cut_ok    = ok_q;
  assign cut_bad   = bad_q;

endmodule

// File: tb/tb_wire_cut_sequencer.sv
// Directed bench: two instances (long and short time limit) share the stimulus.
module tb_wire_cut_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       is_connected;
  logic       cut_req;
  logic [2:0] cut_sel;

  logic [2:0] a_wire, b_wire;
  logic [1:0] a_str, b_str;
  logic [7:0] a_time, b_time;
  logic       a_ok, a_bad, b_ok, b_bad;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  wire_cut_sequencer #(.CYCLES_PER_SEC(4), .TIME_LIMIT_S(200), .MAX_STRIKES(2)) dut_a (
    .clk(clk), .reset(reset), .is_connected(is_connected), .cut_req(cut_req),
    .cut_sel(cut_sel), .cut_wire(a_wire), .strikes(a_str), .time_left(a_time),
    .cut_ok(a_ok), .cut_bad(a_bad));

  wire_cut_sequencer #(.CYCLES_PER_SEC(4), .TIME_LIMIT_S(3), .MAX_STRIKES(2)) dut_b (
    .clk(clk), .reset(reset), .is_connected(is_connected), .cut_req(cut_req),
    .cut_sel(cut_sel), .cut_wire(b_wire), .strikes(b_str), .time_left(b_time),
    .cut_ok(b_ok), .cut_bad(b_bad));

  task automatic chk(input string tag, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; is_connected = 1'b0; cut_req = 1'b0; cut_sel = 3'd0;
    tick();
    reset = 1'b0;
  endtask

  task automatic arm();
    is_connected = 1'b1;
    tick();
  endtask

  task automatic press(input logic [2:0] sel);
    cut_sel = sel; cut_req = 1'b1;
    tick();
  endtask

  task automatic release_btn();
    cut_req = 1'b0;
    tick();
  endtask

  int oks;

  initial begin
    // Reset values
    do_reset();
    chk("rst_a_wire", a_wire, 0);
    chk("rst_a_str",  a_str, 0);
    chk("rst_a_time", a_time, 200);
    chk("rst_b_time", b_time, 3);
    chk("rst_a_ok",   a_ok, 0);
    chk("rst_a_bad",  a_bad, 0);

    // Full correct sequence on the long-limit instance
    arm();
    chk("seq_arm_wire", a_wire, 0);
    oks = 0;
    for (int i = 1; i <= 5; i++) begin
      press(3'(i));
      chk($sformatf("seq_wire%0d", i), a_wire, i);
      oks += int'(a_ok);
      release_btn();
      chk($sformatf("seq_okdrop%0d", i), a_ok, 0);
    end
    chk("seq_ok_count", oks, 5);
    chk("seq_str", a_str, 0);
    chk("seq_time_win", a_time, 198);
    for (int i = 0; i < 8; i++) tick();
    chk("seq_win_sticky", a_wire, 5);
    chk("seq_time_frozen", a_time, 198);

    // Strikes to loss on the short-limit instance
    do_reset();
    arm();
    press(3'd1); release_btn();
    press(3'd2); release_btn();
    chk("str_stage2", b_wire, 2);
    press(3'd5);
    chk("str_bad1", b_bad, 1);
    chk("str_ok1", b_ok, 0);
    chk("str_cnt1", b_str, 1);
    chk("str_wire1", b_wire, 2);
    release_btn();
    chk("str_bad_drop", b_bad, 0);
    press(3'd1);
    chk("str_cnt2", b_str, 2);
    chk("str_lose", b_wire, 7);
    chk("str_bad2", b_bad, 1);
    release_btn();
    press(3'd3);
    chk("str_lose_sticky", b_wire, 7);
    chk("str_lose_nocount", b_str, 2);
    chk("str_lose_nook", b_ok, 0);

    // Countdown timeout
    do_reset();
    arm();
    chk("to_start", b_time, 3);
    for (int j = 1; j <= 12; j++) begin
      tick();
      chk($sformatf("to_time%0d", j), b_time, (j < 4) ? 3 : (j < 8) ? 2 : (j < 12) ? 1 : 0);
      chk($sformatf("to_wire%0d", j), b_wire, (j < 12) ? 0 : 7);
    end
    for (int j = 0; j < 4; j++) tick();
    chk("to_frozen", b_time, 0);
    chk("to_sticky", b_wire, 7);

    // Held button and invalid selects on the long-limit instance
    do_reset();
    arm();
    oks = 0;
    cut_sel = 3'd1; cut_req = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      oks += int'(a_ok);
    end
    chk("hold_wire", a_wire, 1);
    chk("hold_ok_count", oks, 1);
    release_btn();
    oks = 0;
    for (int k = 0; k < 3; k++) begin
      press((k == 0) ? 3'd0 : (k == 1) ? 3'd6 : 3'd7);
      oks += int'(a_ok) + int'(a_bad);
      release_btn();
    end
    chk("inv_wire", a_wire, 1);
    chk("inv_pulses", oks, 0);
    chk("inv_str", a_str, 0);

    // Disconnect in STAGE3 with one strike
    do_reset();
    arm();
    press(3'd1); release_btn();
    press(3'd2); release_btn();
    press(3'd5); release_btn();
    press(3'd3);
    chk("drop_pre_wire", b_wire, 3);
    chk("drop_pre_str", b_str, 1);
    cut_req = 1'b0;
    is_connected = 1'b0;
    tick();
    chk("drop_wire", b_wire, 0);
    chk("drop_str", b_str, 0);
    chk("drop_time", b_time, 3);

    // Reset from WIN, taken while the final cut_ok pulse is high
    arm();
    for (int i = 1; i <= 5; i++) begin
      press(3'(i));
      if (i < 5) release_btn();
    end
    chk("rw_win", a_wire, 5);
    chk("rw_ok", a_ok, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rw_wire", a_wire, 0);
    chk("rw_ok0", a_ok, 0);
    chk("rw_str", a_str, 0);
    chk("rw_time", a_time, 200);

    // Correct cut coinciding with the final timer tick
    do_reset();
    arm();
    for (int j = 1; j <= 11; j++) tick();
    chk("sim_pre_wire", b_wire, 0);
    chk("sim_pre_time", b_time, 1);
    press(3'd1);
    chk("sim_wire", b_wire, 7);
    chk("sim_ok", b_ok, 0);
    chk("sim_time", b_time, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
